// File: rtl/dmem_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// dmem_pkg: shared constants and state type for the APB data memory
// Rev 1.0
// ------------------------------------------------------------------
package dmem_pkg;

  localparam int c_data_w = 32;
  localparam int c_strb_w = c_data_w / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ------------------------------------------------------------------
// dmem_lane_align: strobes, store replication, load extract/extend, errors
// Rev 1.0
// ------------------------------------------------------------------
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]          sel_mod,
  input  logic [1:0]          offset,
  input  logic                is_write,
  input  logic [c_data_w-1:0] wdata,
  input  logic [c_data_w-1:0] rword,
  output logic [c_strb_w-1:0] strobe,
  output logic [c_data_w-1:0] wdata_rep,
  output logic [c_data_w-1:0] rdata,
  output logic                err
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rword[7:0];
    case (offset)
      2'd1:    w_byte = rword[15:8];
      2'd2:    w_byte = rword[23:16];
      2'd3:    w_byte = rword[31:24];
      default: w_byte = rword[7:0];
    endcase
    // odd halfword offsets are flagged as errors, so only lanes 0 and 2 matter
    w_half = offset[1] ? rword[31:16] : rword[15:0];
  end

  always_comb begin
    strobe    = '0;
    wdata_rep = wdata;
    rdata     = '0;
    err       = 1'b0;
    case (sel_mod)
      F3_B: begin
        strobe    = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
        rdata     = {{24{w_byte[7]}}, w_byte};
      end
      F3_BU: begin
        rdata = {24'd0, w_byte};
        err   = is_write;
      end
      F3_H: begin
        strobe    = 4'b0011 << offset;
        wdata_rep = {2{wdata[15:0]}};
        rdata     = {{16{w_half[15]}}, w_half};
        err       = offset[0];
      end
      F3_HU: begin
        rdata = {16'd0, w_half};
        err   = offset[0] | is_write;
      end
      F3_W: begin
        strobe = 4'b1111;
        rdata  = rword;
        err    = (offset != 2'd0);
      end
      default: err = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/apb_dmem_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// apb_dmem_ctrl: APB-slave data memory with wait states and PSLVERR
// Rev 1.0
// ------------------------------------------------------------------
module apb_dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DMEM_W      = 11,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [DMEM_W-1:0]   paddr_i,
  input  logic                psel_i,
  input  logic                penable_i,
  input  logic                pwrite_i,
  input  logic [c_data_w-1:0] pwdata_i,
  input  logic [2:0]          sel_mod_i,
  output logic [c_data_w-1:0] prdata_o,
  output logic                pready_o,
  output logic                pslverr_o
);

  localparam int         c_depth = 2 ** (DMEM_W - 2);
  localparam logic [3:0] c_wait  = 4'(WAIT_CYCLES);

  dmem_state_e         r_state;
  dmem_state_e         w_state_nxt;
  logic [3:0]          r_cnt;
  logic [DMEM_W-1:0]   r_addr;
  logic                r_write;
  logic [c_data_w-1:0] r_wdata;
  logic [2:0]          r_sel;

  logic [c_data_w-1:0] mem [c_depth];

  logic                w_start;
  logic                w_live;
  logic [DMEM_W-1:0]   w_addr;
  logic                w_write;
  logic [c_data_w-1:0] w_wdata;
  logic [2:0]          w_sel;
  logic [c_data_w-1:0] w_rword;
  logic [c_strb_w-1:0] w_strobe;
  logic [c_data_w-1:0] w_wdata_rep;
  logic [c_data_w-1:0] w_rdata;
  logic                w_err;

  assign w_start = psel_i & penable_i;

  // With zero wait states RESP is entered straight from IDLE, so the lane
  // logic must see the live bus there and the latched copies afterwards.
  assign w_live  = (r_state == IDLE);
  assign w_addr  = w_live ? paddr_i   : r_addr;
  assign w_write = w_live ? pwrite_i  : r_write;
  assign w_wdata = w_live ? pwdata_i  : r_wdata;
  assign w_sel   = w_live ? sel_mod_i : r_sel;
  assign w_rword = mem[w_addr[DMEM_W-1:2]];

  dmem_lane_align u_align (
    .sel_mod   (w_sel),
    .offset    (w_addr[1:0]),
    .is_write  (w_write),
    .wdata     (w_wdata),
    .rword     (w_rword),
    .strobe    (w_strobe),
    .wdata_rep (w_wdata_rep),
    .rdata     (w_rdata),
    .err       (w_err)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_start) w_state_nxt = (c_wait != 4'd0) ? WAIT : RESP;
      end
      WAIT: begin
        if (!psel_i)              w_state_nxt = IDLE;
        else if (r_cnt == 4'd1)   w_state_nxt = RESP;
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt     <= '0;
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_sel     <= '0;
      pready_o  <= 1'b0;
      pslverr_o <= 1'b0;
      prdata_o  <= '0;
    end else begin
      if (r_state == IDLE && w_start) begin
        r_addr  <= paddr_i;
        r_write <= pwrite_i;
        r_wdata <= pwdata_i;
        r_sel   <= sel_mod_i;
        r_cnt   <= c_wait;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (r_state != RESP && w_state_nxt == RESP) begin
        pready_o  <= 1'b1;
        pslverr_o <= w_err;
        prdata_o  <= (w_err || w_write) ? '0 : w_rdata;
      end else if (r_state == RESP) begin
        pready_o  <= 1'b0;
        pslverr_o <= 1'b0;
        prdata_o  <= '0;
      end
    end
  end

  // Storage is deliberately not reset; a reset forces IDLE so no write can land.
  always_ff @(posedge clk_i) begin
    if (r_state == RESP && r_write && !w_err) begin
      for (int i = 0; i < c_strb_w; i++) begin
        if (w_strobe[i]) mem[r_addr[DMEM_W-1:2]][8*i +: 8] <= w_wdata_rep[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_dmem_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_apb_dmem_ctrl: three wait-state variants against a byte-level model
// Rev 1.0
// ------------------------------------------------------------------
module tb_apb_dmem_ctrl;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam int W0 = 0, W1 = 1, W2 = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] paddr = '0;
  logic [2:0]  psel = '0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [2:0]  sel_mod = '0;
  logic [31:0] prdata [3];
  logic [2:0]  pready;
  logic [2:0]  pslverr;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;
  int active = -1;
  int acc = 0;
  int lat [3] = '{W0 + 2, W1 + 2, W2 + 2};
  logic [31:0] e_data = '0;
  logic        e_err = 1'b0;
  logic        e_wr = 1'b0;
  logic [7:0]  mb [3][64];

  always #5 clk = ~clk;

  apb_dmem_ctrl #(.DMEM_W(11), .WAIT_CYCLES(W0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .paddr_i(paddr), .psel_i(psel[0]), .penable_i(penable),
    .pwrite_i(pwrite), .pwdata_i(pwdata), .sel_mod_i(sel_mod),
    .prdata_o(prdata[0]), .pready_o(pready[0]), .pslverr_o(pslverr[0]));
  apb_dmem_ctrl #(.DMEM_W(11), .WAIT_CYCLES(W1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .paddr_i(paddr), .psel_i(psel[1]), .penable_i(penable),
    .pwrite_i(pwrite), .pwdata_i(pwdata), .sel_mod_i(sel_mod),
    .prdata_o(prdata[1]), .pready_o(pready[1]), .pslverr_o(pslverr[1]));
  apb_dmem_ctrl #(.DMEM_W(11), .WAIT_CYCLES(W2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .paddr_i(paddr), .psel_i(psel[2]), .penable_i(penable),
    .pwrite_i(pwrite), .pwdata_i(pwdata), .sel_mod_i(sel_mod),
    .prdata_o(prdata[2]), .pready_o(pready[2]), .pslverr_o(pslverr[2]));

  function automatic bit merr(bit wr, logic [2:0] f3, int addr);
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
    if (wr && f3 >= 3'b100) return 1'b1;
    if ((f3 == LH || f3 == LHU) && (addr % 2 != 0)) return 1'b1;
    if (f3 == LW && (addr % 4 != 0)) return 1'b1;
    return 1'b0;
  endfunction

  // little-endian byte memory: loads gather bytes and extend arithmetically
  function automatic logic [31:0] mload(int k, logic [2:0] f3, int addr);
    int unsigned v;
    v = 0;
    case (f3)
      LB, LBU: begin
        v = mb[k][addr];
        if (f3 == LB && v >= 128) v = v + 32'hFFFFFF00;
      end
      LH, LHU: begin
        v = mb[k][addr] + 256 * mb[k][addr+1];
        if (f3 == LH && v >= 32768) v = v + 32'hFFFF0000;
      end
      LW: v = mb[k][addr] + 256 * mb[k][addr+1] + 65536 * mb[k][addr+2] + 16777216 * mb[k][addr+3];
      default: v = 0;
    endcase
    return v;
  endfunction

  task automatic mstore(int k, logic [2:0] f3, int addr, logic [31:0] data);
    int n;
    n = (f3 == LB) ? 1 : (f3 == LH) ? 2 : 4;
    for (int i = 0; i < n; i++) mb[k][addr+i] = 8'(data >> (8 * i));
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // abort_kind: 0 none, 1 drop psel, 2 pulse reset -- after abort_after access cycles
  task automatic xfer(input int k, input bit wr, input logic [2:0] f3, input logic [10:0] addr,
                      input logic [31:0] data, input int abort_kind, input int abort_after,
                      output logic [31:0] got, output logic gerr, output int cyc);
    bit seen;
    bit ex_err;
    int a;
    a = int'(addr);
    ex_err = merr(wr, f3, a);
    got = '0; gerr = 1'b0; cyc = 0; seen = 1'b0;
    @(posedge clk); #1;
    paddr = addr; pwrite = wr; pwdata = data; sel_mod = f3; psel[k] = 1'b1; penable = 1'b0;
    e_err = ex_err; e_wr = wr;
    e_data = (wr || ex_err) ? 32'h0 : mload(k, f3, a);
    @(posedge clk); #1;
    penable = 1'b1; acc = 1; active = k;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (pready[k]) begin
        seen = 1'b1; got = prdata[k]; gerr = pslverr[k]; cyc = acc;
        break;
      end
      if (abort_kind != 0 && acc == abort_after) break;
      @(posedge clk); #1;
      acc++;
    end
    @(posedge clk); #1;
    active = -1; psel[k] = 1'b0; penable = 1'b0;
    if (abort_kind == 2) begin
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
    end else if (abort_kind == 0 && !seen) begin
      vectors++; miscompares++;
      $display("FAIL timeout dut%0d addr %h: no pready within 20 cycles", k, addr);
    end
    if (seen && wr && !ex_err) mstore(k, f3, a, data);
  endtask

  always @(negedge clk) begin : cmp
    logic        er;
    logic [31:0] ed;
    if (chk_en) begin
      for (int j = 0; j < 3; j++) begin
        er = (active == j) && (acc == lat[j]);
        ed = er ? e_data : 32'h0;
        vectors++;
        if (pready[j] !== er || pslverr[j] !== (er & e_err) || (!(er && e_wr) && prdata[j] !== ed)) begin
          miscompares++;
          $display("FAIL cycle dut%0d t=%0t: rdy/err/data got %b/%b/%h expected %b/%b/%h",
                   j, $time, pready[j], pslverr[j], prdata[j], er, er & e_err, ed);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] g;
    logic        ge;
    int          cy;
    logic [31:0] old;
    logic [2:0]  f3;
    bit          wr;

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ready%0d", k), 32'(pready[k]), 32'h0);
      chk($sformatf("rst_err%0d", k), 32'(pslverr[k]), 32'h0);
      chk($sformatf("rst_data%0d", k), prdata[k], 32'h0);
    end
    rst_n = 1'b1;
    chk_en = 1'b1;

    for (int k = 0; k < 3; k++)
      for (int w = 0; w < 16; w++)
        xfer(k, 1'b1, LW, 11'(w * 4), $urandom, 0, 0, g, ge, cy);

    // hand-computed sequence on the one-wait-state instance
    xfer(1, 1'b1, LW,  11'h010, 32'hDEADBEEF, 0, 0, g, ge, cy);
    xfer(1, 1'b0, LW,  11'h010, 32'h0, 0, 0, g, ge, cy);
    chk("lw010", g, 32'hDEADBEEF);
    chk("lw010_cycle", 32'(cy), 32'd3);
    xfer(1, 1'b1, LB,  11'h013, 32'h00000080, 0, 0, g, ge, cy);
    xfer(1, 1'b0, LW,  11'h010, 32'h0, 0, 0, g, ge, cy);
    chk("lw010_after_sb", g, 32'h80ADBEEF);
    xfer(1, 1'b0, LB,  11'h013, 32'h0, 0, 0, g, ge, cy);
    chk("lb013", g, 32'hFFFFFF80);
    xfer(1, 1'b0, LBU, 11'h013, 32'h0, 0, 0, g, ge, cy);
    chk("lbu013", g, 32'h00000080);
    xfer(1, 1'b1, LW,  11'h020, 32'h11111111, 0, 0, g, ge, cy);
    xfer(1, 1'b1, LH,  11'h022, 32'h00008001, 0, 0, g, ge, cy);
    xfer(1, 1'b0, LW,  11'h020, 32'h0, 0, 0, g, ge, cy);
    chk("lw020_after_sh", g, 32'h80011111);
    xfer(1, 1'b0, LH,  11'h022, 32'h0, 0, 0, g, ge, cy);
    chk("lh022", g, 32'hFFFF8001);
    xfer(1, 1'b0, LHU, 11'h022, 32'h0, 0, 0, g, ge, cy);
    chk("lhu022", g, 32'h00008001);

    xfer(1, 1'b0, LW,     11'h012, 32'h0, 0, 0, g, ge, cy);
    chk("lw012_err", 32'(ge), 32'h1);
    chk("lw012_data", g, 32'h0);
    xfer(1, 1'b1, LH,     11'h021, 32'hFFFFFFFF, 0, 0, g, ge, cy);
    chk("sh021_err", 32'(ge), 32'h1);
    xfer(1, 1'b0, 3'b011, 11'h010, 32'h0, 0, 0, g, ge, cy);
    chk("f3_011_err", 32'(ge), 32'h1);
    chk("f3_011_data", g, 32'h0);
    xfer(1, 1'b0, LW,     11'h010, 32'h0, 0, 0, g, ge, cy);
    chk("lw010_after_err", g, 32'h80ADBEEF);
    chk("lw010_noerr", 32'(ge), 32'h0);

    // latency sweep
    xfer(0, 1'b0, LW, 11'h010, 32'h0, 0, 0, g, ge, cy);
    chk("w0_cycle", 32'(cy), 32'd2);
    xfer(2, 1'b0, LW, 11'h010, 32'h0, 0, 0, g, ge, cy);
    chk("w4_cycle", 32'(cy), 32'd6);

    // setup phase held alone must never start a transfer
    for (int k = 0; k < 3; k += 2) begin
      @(posedge clk); #1;
      paddr = 11'h010; pwrite = 1'b1; sel_mod = LW; psel[k] = 1'b1; penable = 1'b0;
      repeat (5) begin
        @(negedge clk);
        chk($sformatf("setup_only%0d", k), 32'(pready[k]), 32'h0);
      end
      @(posedge clk); #1;
      psel[k] = 1'b0;
    end

    // aborts during WAIT leave memory untouched
    old = mload(2, LW, 32'h030);
    xfer(2, 1'b1, LW, 11'h030, 32'h12345678, 1, 2, g, ge, cy);
    xfer(2, 1'b0, LW, 11'h030, 32'h0, 0, 0, g, ge, cy);
    chk("lw030_after_psel_drop", g, old);
    xfer(2, 1'b1, LW, 11'h030, 32'h12345678, 2, 3, g, ge, cy);
    for (int k = 0; k < 3; k++) chk($sformatf("post_rst_data%0d", k), prdata[k], 32'h0);
    xfer(2, 1'b0, LW, 11'h030, 32'h0, 0, 0, g, ge, cy);
    chk("lw030_after_reset", g, old);

    // randomized traffic over the preloaded region
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 60; n++) begin
        wr = 1'($urandom_range(0, 1));
        f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 7)) : LW;
        if (wr && $urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
        xfer(k, wr, f3, 11'($urandom_range(0, 63)), $urandom, 0, 0, g, ge, cy);
      end
    end

    repeat (2) @(posedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_dmem_ctrl.md
Name: apb_dmem_ctrl

Overview:
Parametrised APB-slave data memory for the pipelined RV32 core; successor of the first-generation data memory.
- Adds configurable wait states, registered read data and PSLVERR.
- Byte and halfword accesses work at any legal byte offset, not only lane 0.
- Store strobes are derived internally from funct3 and address.
- Sits on the MEM stage load/store path.

Parameters:
DMEM_W, 11, byte-address width; depth is 2**(DMEM_W-2) 32-bit words.
WAIT_CYCLES, 1, extra access-phase cycles before PREADY (0..15).

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
paddr_i  in  DMEM_W  byte address
psel_i  in  1  APB select
penable_i  in  1  APB enable (access phase)
pwrite_i  in  1  1=store, 0=load
pwdata_i  in  32  store data, right-justified (SB uses [7:0], SH uses [15:0])
sel_mod_i  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
prdata_o  out  32  load data, aligned and extended
pready_o  out  1  transfer complete
pslverr_o  out  1  transfer error, valid with pready_o

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE; pready_o=0, pslverr_o=0, prdata_o=0, wait counter=0.
  - Memory contents are not reset and are retained across reset.
  - Any in-flight write is discarded.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On psel_i & penable_i, latch paddr/pwrite/pwdata/sel_mod and compute error.
  - Load cnt=WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, else RESP.
- WAIT:
  - cnt decrements each cycle; at cnt==1 go to RESP.
  - If psel_i drops (protocol abort), return to IDLE with no write and outputs unchanged.
- RESP:
  - pready_o=1 for exactly one cycle; next state is IDLE.
  - pready_o, prdata_o and pslverr_o are registered and change only on entry to and exit from RESP.
- Latency:
  - pready_o rises in access-phase cycle WAIT_CYCLES+2 (first access cycle = cycle 1).
  - Minimum access phase is 2 cycles.
- Inputs must be held stable by the master until pready_o; the block uses latched copies.
- Byte offset is a = paddr[1:0]; word index is paddr[DMEM_W-1:2].
- Load data:
  - B/BU: lane a, sign- or zero-extended to 32 bits.
  - H/HU: lanes a+1:a, sign- or zero-extended.
  - W: full word.
- Store strobes:
  - SB: strobe = 0001<<a; the byte is replicated to all lanes.
  - SH: strobe = 0011<<a; the halfword is replicated to both halves.
  - SW: strobe = 1111.
- Error (pslverr_o=1 in RESP) on any of:
  - H/HU with a[0]=1;
  - W with a!=0;
  - funct3 011, 110 or 111;
  - store with funct3[2]=1.
- On error: no memory write, prdata_o=0.
- Load data is sampled from memory when entering RESP; prdata_o returns to 0 when leaving RESP.
- Store commits on the clock edge that leaves RESP, affecting only strobed bytes.
  - A load issued immediately afterwards sees the new data.
- A read-only transfer never modifies memory.
- Back-to-back transfers:
  - APB setup cycle (psel=1, penable=0) in IDLE is ignored.
  - Maximum throughput is one transfer per WAIT_CYCLES+3 cycles.

Decomposition:
- Package dmem_pkg holds:
  - funct3 constants F3_B/H/W/BU/HU;
  - state enum dmem_state_e {IDLE, WAIT, RESP};
  - strobe width and data width (32) constants.
- One combinational sub-module, dmem_lane_align, holds:
  - strobe generation;
  - store-data replication;
  - load lane select and extension;
  - misalignment/illegal detection.
- The FSM, counter and storage array stay in apb_dmem_ctrl.

Test Plan:
- Reset with WAIT_CYCLES=1 -> pready_o=0, pslverr_o=0, prdata_o=0.
  - SW addr 0x010 data 0xDEADBEEF, then LW 0x010 -> prdata_o=0xDEADBEEF.
  - pready_o high in access cycle 3 only.
- SB 0x013 data 0x80, then LW 0x010 -> 0x80ADBEEF.
  - LB 0x013 -> 0xFFFFFF80; LBU 0x013 -> 0x00000080.
- SH 0x022 data 0x8001 over a word preloaded 0x11111111, then LW 0x020 -> 0x80011111.
  - LH 0x022 -> 0xFFFF8001; LHU 0x022 -> 0x00008001.
- Misalignment: LW 0x012, SH 0x021, funct3=011 -> pslverr_o=1 with pready_o.
  - prdata_o=0; a following LW 0x010 is unchanged.
- Parameter sweep WAIT_CYCLES=0 and 4 -> pready_o in access cycle 2 and 6 respectively.
  - Setup cycle alone never triggers a transfer.
- rst_ni low during WAIT of SW 0x030 0x12345678 -> outputs reset, no pready_o.
  - After reset, LW 0x030 returns the prior contents.
  - Also: psel_i dropped mid-WAIT -> FSM returns to IDLE, no write.
